// File: rtl/cdc_fifo_wr_arbiter_if.sv
// Bundle of the requester handshake and FIFO write-side signals.
// The master modport is the arbiter's view. The slave modport is the
// environment's view: requesters plus the FIFO write port.
interface cdc_fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wr_full;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wr_data;

    modport master (
        input  req_valid,
        input  req_data,
        input  wr_full,
        output req_ready,
        output wr_en,
        output wr_data
    );

    modport slave (
        output req_valid,
        output req_data,
        output wr_full,
        input  req_ready,
        input  wr_en,
        input  wr_data
    );

endinterface

// File: rtl/cdc_fifo_wr_arbiter.sv
// Round-robin write arbiter in front of the write side of a CDC FIFO.
// Each grant covers a burst of up to BURST_MAX writes. A burst ends early
// when the granted requester drops valid. A full FIFO only stalls the burst
// and never ends it.
module cdc_fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst_n,
    cdc_fifo_wr_arbiter_if.master      bus,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic [15:0]                full_stall_cnt
);

    localparam int         GNT_W      = $clog2(NUM_REQ);
    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [GNT_W-1:0]   last_gnt;
    logic [GNT_W-1:0]   arb_pick;
    logic [GNT_W-1:0]   cand;
    logic               arb_found;
    logic [3:0]         burst_cnt;
    logic               gnt_valid;

    assign gnt_valid = bus.req_valid[gnt_id];

    // Rotating-priority pick: scan upward from last_gnt+1, wrapping, so the
    // requester served last is considered last.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GNT_W'((int'(last_gnt) + k) % NUM_REQ);
            if (!arb_found && bus.req_valid[cand]) begin
                arb_found = 1'b1;
                arb_pick  = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant from IDLE, leave BURST on release or the final write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!gnt_valid) begin
                    state_d = IDLE;
                end else if (bus.wr_en && (burst_cnt == BURST_LAST)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: only the granted requester is acked, and only when the FIFO can take the word.
    always_comb begin
        bus.req_ready = '0;
        bus.wr_en     = (state_q == BURST) && gnt_valid && !bus.wr_full && wr_rst_n;
        bus.req_ready[gnt_id] = bus.wr_en;
        bus.wr_data   = bus.req_data[gnt_id*DATA_WIDTH +: DATA_WIDTH];
        busy          = (state_q == BURST);
    end

    // Grant bookkeeping: capture the pick, count burst writes, remember who was served.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            gnt_id    <= '0;
            last_gnt  <= GNT_W'(NUM_REQ - 1);
            burst_cnt <= 4'd0;
        end else begin
            if (state_q == IDLE) begin
                if (arb_found) begin
                    gnt_id    <= arb_pick;
                    burst_cnt <= 4'd0;
                end
            end else begin
                if (bus.wr_en) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
                if (state_d == IDLE) begin
                    last_gnt <= gnt_id;
                end
            end
        end
    end

    // Saturating count of cycles where the granted requester was blocked by a full FIFO.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            full_stall_cnt <= 16'd0;
        end else if ((state_q == BURST) && gnt_valid && bus.wr_full &&
                     (full_stall_cnt != 16'hFFFF)) begin
            full_stall_cnt <= full_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// Directed bench for cdc_fifo_wr_arbiter with DATA_WIDTH=4, NUM_REQ=4 and BURST_MAX=4.
// Inputs change on the falling edge. Outputs are checked 1 ns later, which
// is mid-cycle and well away from the rising edge.
module tb_cdc_fifo_wr_arbiter;

    logic        wr_clk;
    logic        wr_rst_n;
    logic [1:0]  gnt_id;
    logic        busy;
    logic [15:0] full_stall_cnt;

    int compared;
    int mismatched;

    // Requester data 16'hD5A3: slices 0..3 are 3, A, 5, D.
    logic [3:0] exp_data [4];

    cdc_fifo_wr_arbiter_if #(.DATA_WIDTH(4), .NUM_REQ(4)) bus ();

    cdc_fifo_wr_arbiter #(
        .DATA_WIDTH(4),
        .NUM_REQ   (4),
        .BURST_MAX (4)
    ) dut (
        .wr_clk        (wr_clk),
        .wr_rst_n      (wr_rst_n),
        .bus           (bus),
        .gnt_id        (gnt_id),
        .busy          (busy),
        .full_stall_cnt(full_stall_cnt)
    );

    // Free-running clock with the first rising edge at 5 ns.
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    // Checker: the arbiter never writes while the FIFO is full.
    no_write_when_full: assert property (@(posedge wr_clk) bus.wr_en |-> !bus.wr_full)
        else begin
            mismatched++;
            $display("[TB] FAIL no_write_when_full: wr_en=1 with wr_full=1 at %0t", $time);
        end

    // Checker: at most one requester is acked per cycle.
    ready_onehot0: assert property (@(posedge wr_clk) $onehot0(bus.req_ready))
        else begin
            mismatched++;
            $display("[TB] FAIL ready_onehot0: req_ready=%b at %0t", bus.req_ready, $time);
        end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic full, input logic rst_n);
        @(negedge wr_clk);
        bus.req_valid = valid;
        bus.wr_full   = full;
        wr_rst_n      = rst_n;
        #1;
    endtask

    task automatic checkCycle(input string tag, input logic busy_e, input logic [1:0] gnt_e,
                              input logic wr_en_e, input logic [3:0] ready_e);
        checkOutput({tag, "_busy"},  32'(busy),          32'(busy_e));
        checkOutput({tag, "_gnt"},   32'(gnt_id),        32'(gnt_e));
        checkOutput({tag, "_wr_en"}, 32'(bus.wr_en),     32'(wr_en_e));
        checkOutput({tag, "_ready"}, 32'(bus.req_ready), 32'(ready_e));
        if (wr_en_e) begin
            checkOutput({tag, "_data"}, 32'(bus.wr_data), 32'(exp_data[gnt_e]));
        end
    endtask

    // Two reset cycles. The second cycle sees the values registered by the first reset edge.
    task automatic resetDut(input string tag, input logic [3:0] valid);
        applyStimulus(valid, 1'b0, 1'b0);
        checkOutput({tag, "_rst_wr_en"}, 32'(bus.wr_en),     32'd0);
        checkOutput({tag, "_rst_ready"}, 32'(bus.req_ready), 32'd0);
        applyStimulus(valid, 1'b0, 1'b0);
        checkOutput({tag, "_rst_busy"},  32'(busy),           32'd0);
        checkOutput({tag, "_rst_gnt"},   32'(gnt_id),         32'd0);
        checkOutput({tag, "_rst_stall"}, 32'(full_stall_cnt), 32'd0);
    endtask

    // One arbitration cycle followed by nw write cycles for requester g.
    task automatic runBurst(input string tag, input logic [3:0] valid, input logic [1:0] prev_g,
                            input logic [1:0] g, input int nw);
        applyStimulus(valid, 1'b0, 1'b1);
        checkCycle({tag, "_idle"}, 1'b0, prev_g, 1'b0, 4'b0000);
        for (int i = 0; i < nw; i++) begin
            applyStimulus(valid, 1'b0, 1'b1);
            checkCycle({tag, "_wr"}, 1'b1, g, 1'b1, 4'(1 << g));
        end
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        exp_data[0]     = 4'h3;
        exp_data[1]     = 4'hA;
        exp_data[2]     = 4'h5;
        exp_data[3]     = 4'hD;
        wr_rst_n        = 1'b0;
        bus.req_valid   = 4'b0000;
        bus.req_data    = 16'hD5A3;
        bus.wr_full     = 1'b0;

        // All four requesting: the grant rotates 0,1,2,3,0 with 4-write bursts.
        resetDut("rr", 4'b1111);
        runBurst("rr_g0", 4'b1111, 2'd0, 2'd0, 4);
        runBurst("rr_g1", 4'b1111, 2'd0, 2'd1, 4);
        runBurst("rr_g2", 4'b1111, 2'd1, 2'd2, 4);
        runBurst("rr_g3", 4'b1111, 2'd2, 2'd3, 4);
        runBurst("rr_g0b", 4'b1111, 2'd3, 2'd0, 4);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkCycle("rr_end", 1'b0, 2'd0, 1'b0, 4'b0000);
        checkOutput("rr_stall", 32'(full_stall_cnt), 32'd0);

        // Requester 2 alone: back-to-back 4-write bursts, each preceded by one idle cycle.
        resetDut("solo", 4'b0100);
        runBurst("solo_a", 4'b0100, 2'd0, 2'd2, 4);
        runBurst("solo_b", 4'b0100, 2'd2, 2'd2, 4);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkCycle("solo_end", 1'b0, 2'd2, 1'b0, 4'b0000);

        // Requester 1: two writes, 5 full cycles, two more writes, then the burst ends.
        resetDut("full", 4'b0010);
        runBurst("full_pre", 4'b0010, 2'd0, 2'd1, 2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0010, 1'b1, 1'b1);
            checkCycle("full_stall", 1'b1, 2'd1, 1'b0, 4'b0000);
        end
        applyStimulus(4'b0010, 1'b0, 1'b1);
        checkCycle("full_wr3", 1'b1, 2'd1, 1'b1, 4'b0010);
        checkOutput("full_stall_cnt", 32'(full_stall_cnt), 32'd5);
        applyStimulus(4'b0010, 1'b0, 1'b1);
        checkCycle("full_wr4", 1'b1, 2'd1, 1'b1, 4'b0010);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkCycle("full_exit", 1'b0, 2'd1, 1'b0, 4'b0000);
        checkOutput("full_stall_hold", 32'(full_stall_cnt), 32'd5);

        // Requester 3 writes once and releases. The next grant wraps around to requester 0.
        resetDut("rel", 4'b1000);
        applyStimulus(4'b1000, 1'b0, 1'b1);
        checkCycle("rel_idle", 1'b0, 2'd0, 1'b0, 4'b0000);
        applyStimulus(4'b1001, 1'b0, 1'b1);
        checkCycle("rel_wr", 1'b1, 2'd3, 1'b1, 4'b1000);
        applyStimulus(4'b0001, 1'b0, 1'b1);
        checkCycle("rel_drop", 1'b1, 2'd3, 1'b0, 4'b0000);
        applyStimulus(4'b1001, 1'b0, 1'b1);
        checkCycle("rel_idle2", 1'b0, 2'd3, 1'b0, 4'b0000);
        applyStimulus(4'b1001, 1'b0, 1'b1);
        checkCycle("rel_wrap", 1'b1, 2'd0, 1'b1, 4'b0001);

        // Reset asserted mid-burst after two writes and one full cycle.
        resetDut("mid", 4'b0110);
        runBurst("mid_pre", 4'b0110, 2'd0, 2'd1, 1);
        applyStimulus(4'b0110, 1'b1, 1'b1);
        checkCycle("mid_full", 1'b1, 2'd1, 1'b0, 4'b0000);
        applyStimulus(4'b0110, 1'b0, 1'b1);
        checkCycle("mid_wr2", 1'b1, 2'd1, 1'b1, 4'b0010);
        checkOutput("mid_stall1", 32'(full_stall_cnt), 32'd1);
        applyStimulus(4'b0110, 1'b0, 1'b0);
        checkOutput("mid_rst_wr_en", 32'(bus.wr_en),     32'd0);
        checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        applyStimulus(4'b0110, 1'b0, 1'b1);
        checkCycle("mid_after", 1'b0, 2'd0, 1'b0, 4'b0000);
        checkOutput("mid_stall0", 32'(full_stall_cnt), 32'd0);
        applyStimulus(4'b0110, 1'b0, 1'b1);
        checkCycle("mid_regrant", 1'b1, 2'd1, 1'b1, 4'b0010);

        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
